pc_sequencer: RTL

//   Program-counter sequencer directly upstream of PilhaInstrucoes (the return-address stack).

---
 rtl/lab3_pkg.sv | 26 ++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lab3_pkg.sv
// Shared definitions for the program-counter sequencer: decoded operation
// encodings, sequencer state encoding and fault codes reported to software.
package lab3_pkg;

  // Decoded operation presented with instr_valid; 5..7 are reserved and
  // behave like NEXT.
  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  // Sequencer states: normal fetch, one-cycle wait for popped return
  // address, and terminal fault halt.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } seq_state_e;

  // Sticky fault codes.
  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_OVF  = 2'd1;
  localparam logic [1:0] FLT_UNF  = 2'd2;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding fetch. Selects the next PC for
// sequential, jump, branch, call and return flow, driving push/pop strobes
// to the return-address stack that sits next to it. Overflow/underflow of
// that stack halts the sequencer with a sticky fault until reset.
module pc_sequencer
  import lab3_pkg::*;
#(
  parameter int                    WIDTH_DATA = 32,
  parameter logic [WIDTH_DATA-1:0] RESET_PC   = {WIDTH_DATA{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic                  stall,
  input  logic [2:0]            op,
  input  logic [WIDTH_DATA-1:0] target,
  input  logic                  cond,
  output logic [WIDTH_DATA-1:0] pc,
  output logic                  pc_valid,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [WIDTH_DATA-1:0] stack_data_in,
  input  logic [WIDTH_DATA-1:0] stack_data_out,
  input  logic                  stack_full,
  input  logic                  stack_empty,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam logic [WIDTH_DATA-1:0] PC_ONE = {{(WIDTH_DATA-1){1'b0}}, 1'b1};

  seq_state_e            state_q, state_d;
  logic [WIDTH_DATA-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;
  logic                  push_s, pop_s;
  logic                  accept_s;
  logic [WIDTH_DATA-1:0] pc_inc_s;

  // Sequential successor wraps modulo 2^WIDTH_DATA; also the return address.
  assign pc_inc_s = pc_q + PC_ONE;
  assign accept_s = instr_valid & ~stall;

  // Next-state, next-PC and stack strobe selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    case (state_q)
      RUN: begin
        pc_valid_d = 1'b1;
        if (accept_s) begin
          case (op)
            OP_JUMP: begin
              pc_d = target;
            end
            OP_BRANCH: begin
              if (cond) begin
                pc_d = target;
              end else begin
                pc_d = pc_inc_s;
              end
            end
            OP_CALL: begin
              if (stack_full) begin
                state_d      = HALT;
                pc_valid_d   = 1'b0;
                fault_d      = 1'b1;
                fault_code_d = FLT_OVF;
              end else begin
                push_s = 1'b1;
                pc_d   = target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state_d      = HALT;
                pc_valid_d   = 1'b0;
                fault_d      = 1'b1;
                fault_code_d = FLT_UNF;
              end else begin
                // PC is held; the popped address arrives next cycle.
                pop_s      = 1'b1;
                state_d    = RET_WAIT;
                pc_valid_d = 1'b0;
              end
            end
            default: begin
              pc_d = pc_inc_s;
            end
          endcase
        end else begin
          pc_d = pc_q;
        end
      end
      RET_WAIT: begin
        // Return always completes, regardless of stall or instr_valid.
        pc_d       = stack_data_out;
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      HALT: begin
        pc_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
      default: begin
        // Unreachable encoding: stop fetching rather than run wild.
        state_d    = HALT;
        pc_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
    endcase
  end

  // State and PC registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Stack strobes are same-cycle so the stack captures on the accepting
  // edge; they are forced low while reset is held.
  assign stack_push    = push_s & reset;
  assign stack_pop     = pop_s & reset;
  assign stack_data_in = pc_inc_s;
  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;

endmodule
